// File: rtl/core_pkg.sv
// core_pkg: shared register-address width and EX operand forward-select encodings.
package core_pkg;
    localparam int REG_AW = 5;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_LO  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;
endpackage

// File: rtl/lo_scoreboard.sv
// lo_scoreboard: busy bits and in-flight count for long-latency ops, with a same-cycle done bypass.
module lo_scoreboard #(
    parameter int NUM_SRC         = 2,
    parameter int REG_AW          = core_pkg::REG_AW,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_SRC*REG_AW-1:0] i_rs,
    input  logic                      i_issue,
    input  logic [REG_AW-1:0]         i_issue_rd,
    input  logic                      i_done,
    input  logic [REG_AW-1:0]         i_done_rd,
    output logic [NUM_SRC-1:0]        o_src_busy,
    output logic [NUM_SRC-1:0]        o_src_lo_fwd,
    output logic                      o_issue_busy,
    output logic                      o_full
);
    localparam int NREG = 1 << REG_AW;
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    logic [NREG-1:0]   busy_q, busy_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [REG_AW-1:0] rs [NUM_SRC];
    // A completing op frees its register in the same cycle via the writeback-bus bypass
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign rs[k]           = i_rs[k*REG_AW +: REG_AW];
        assign o_src_busy[k]   = busy_q[rs[k]] && !(i_done && i_done_rd == rs[k]);
        assign o_src_lo_fwd[k] = busy_q[rs[k]] && i_done && i_done_rd == rs[k];
    end
    assign o_issue_busy = busy_q[i_issue_rd] && !(i_done && i_done_rd == i_issue_rd);
    assign o_full       = outstanding_q == OW'(MAX_OUTSTANDING);
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NREG; r++)
            busy_d[r] = (i_issue && i_issue_rd == REG_AW'(r)) ||
                        (busy_q[r] && !(i_done && i_done_rd == REG_AW'(r)));
        outstanding_d = (i_issue && !i_done) ? outstanding_q + OW'(1) :
                        (!i_issue && i_done && outstanding_q != '0) ? outstanding_q - OW'(1) :
                        outstanding_q;
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX operand forwarding (MEM > WB > LO), load-use and long-latency
// scoreboard stall detection, and a saturating stalled-cycle counter.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC         = 2,
    parameter int REG_AW          = core_pkg::REG_AW,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_SRC*REG_AW-1:0] i_rs,
    input  logic [NUM_SRC-1:0]        i_rs_used,
    input  logic [REG_AW-1:0]         i_EX_Rd,
    input  logic                      i_ctrl_EX_MemRead,
    input  logic [REG_AW-1:0]         i_MEM_Rd,
    input  logic                      i_ctrl_MEM_RegWrite,
    input  logic [REG_AW-1:0]         i_WB_Rd,
    input  logic                      i_ctrl_WB_RegWrite,
    input  logic                      i_lo_issue,
    input  logic [REG_AW-1:0]         i_lo_issue_rd,
    input  logic                      i_lo_done,
    input  logic [REG_AW-1:0]         i_lo_done_rd,
    output logic [2*NUM_SRC-1:0]      o_ctrl_Forward,
    output logic                      o_stall,
    output logic                      o_lo_full,
    output logic [CNT_W-1:0]          o_stall_cnt
);
    import core_pkg::*;
    logic [REG_AW-1:0]  rs [NUM_SRC];
    logic [NUM_SRC-1:0] src_busy, src_lo_fwd, hazard;
    logic               issue_busy, issue_acc;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_rs
        assign rs[k] = i_rs[k*REG_AW +: REG_AW];
    end
    lo_scoreboard #(
        .NUM_SRC(NUM_SRC),
        .REG_AW(REG_AW),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_lo (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_rs(i_rs),
        .i_issue(issue_acc),
        .i_issue_rd(i_lo_issue_rd),
        .i_done(i_lo_done),
        .i_done_rd(i_lo_done_rd),
        .o_src_busy(src_busy),
        .o_src_lo_fwd(src_lo_fwd),
        .o_issue_busy(issue_busy),
        .o_full(o_lo_full)
    );
    always_comb begin
        o_ctrl_Forward = '0;
        hazard         = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            o_ctrl_Forward[2*s +: 2] = (rs[s] == '0) ? FWD_RF :
                                       (i_ctrl_MEM_RegWrite && i_MEM_Rd == rs[s]) ? FWD_MEM :
                                       (i_ctrl_WB_RegWrite && i_WB_Rd == rs[s]) ? FWD_WB :
                                       src_lo_fwd[s] ? FWD_LO : FWD_RF;
            hazard[s] = i_rs_used[s] && rs[s] != '0 &&
                        ((i_ctrl_EX_MemRead && i_EX_Rd == rs[s]) || src_busy[s]);
        end
    end
    // Issue is held back on overflow or on a WAW against a still-busy destination
    assign o_stall     = |hazard || (i_lo_issue && (o_lo_full || (i_lo_issue_rd != '0 && issue_busy)));
    assign issue_acc   = i_lo_issue && !o_stall;
    assign stall_cnt_d = (o_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: vector table for forwarding/load-use plus sequences for the
// long-latency scoreboard, counter saturation and asynchronous reset.
module tb_fwd_hazard_scoreboard;
    localparam int NS = 2, AW = 5, CW = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [NS*AW-1:0] rs;
    logic [NS-1:0] used;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd, iss_rd, dn_rd;
    logic ex_mr, mem_rw, wb_rw, iss, dn;
    logic [2*NS-1:0] fwd;
    logic stall, full;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(.NUM_SRC(NS), .REG_AW(AW), .MAX_OUTSTANDING(2), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_rs(rs), .i_rs_used(used),
        .i_EX_Rd(ex_rd), .i_ctrl_EX_MemRead(ex_mr),
        .i_MEM_Rd(mem_rd), .i_ctrl_MEM_RegWrite(mem_rw),
        .i_WB_Rd(wb_rd), .i_ctrl_WB_RegWrite(wb_rw),
        .i_lo_issue(iss), .i_lo_issue_rd(iss_rd), .i_lo_done(dn), .i_lo_done_rd(dn_rd),
        .o_ctrl_Forward(fwd), .o_stall(stall), .o_lo_full(full), .o_stall_cnt(cnt)
    );

    typedef struct {
        string name;
        logic [AW-1:0] rs0, rs1;
        logic [1:0] used;
        logic ex_mr;
        logic [AW-1:0] ex_rd;
        logic mem_rw;
        logic [AW-1:0] mem_rd;
        logic wb_rw;
        logic [AW-1:0] wb_rd;
        logic iss;
        logic [AW-1:0] iss_rd;
        logic dn;
        logic [AW-1:0] dn_rd;
        logic [3:0] e_fwd;
        logic e_stall, e_full;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[10];
    int n_cmp = 0, n_bad = 0;

    function automatic vec_t mk(input string n, input logic [AW-1:0] r0, r1, input logic [1:0] u,
                                input logic em, input logic [AW-1:0] er, input logic mw,
                                input logic [AW-1:0] mr, input logic ww, input logic [AW-1:0] wr,
                                input logic is, input logic [AW-1:0] ir, input logic d,
                                input logic [AW-1:0] dr, input logic [3:0] f, input logic s, fl);
        vec_t v;
        v.name = n; v.rs0 = r0; v.rs1 = r1; v.used = u; v.ex_mr = em; v.ex_rd = er;
        v.mem_rw = mw; v.mem_rd = mr; v.wb_rw = ww; v.wb_rd = wr;
        v.iss = is; v.iss_rd = ir; v.dn = d; v.dn_rd = dr;
        v.e_fwd = f; v.e_stall = s; v.e_full = fl;
        return v;
    endfunction

    function automatic vec_t sq(input string n, input logic [AW-1:0] r0, input logic [1:0] u,
                                input logic is, input logic [AW-1:0] ir, input logic d,
                                input logic [AW-1:0] dr, input logic [3:0] f, input logic s, fl);
        return mk(n, r0, 0, u, 0, 0, 0, 0, 0, 0, is, ir, d, dr, f, s, fl);
    endfunction

    task automatic chk(input string what, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", what, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        rs = {v.rs1, v.rs0}; used = v.used; ex_mr = v.ex_mr; ex_rd = v.ex_rd;
        mem_rw = v.mem_rw; mem_rd = v.mem_rd; wb_rw = v.wb_rw; wb_rd = v.wb_rd;
        iss = v.iss; iss_rd = v.iss_rd; dn = v.dn; dn_rd = v.dn_rd;
    endtask

    task automatic cmp_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = exp_q.pop_front();
            chk({e.name, ".fwd"}, 16'(fwd), 16'(e.e_fwd));
            chk({e.name, ".stall"}, 16'(stall), 16'(e.e_stall));
            chk({e.name, ".full"}, 16'(full), 16'(e.e_full));
        end
    endtask

    task automatic step(input vec_t v);
        apply(v);
        exp_q.push_back(v);
        @(negedge clk);
        cmp_out();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(sq("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lu, hold3;
        apply(sq("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        chk("reset.fwd", 16'(fwd), 0);
        chk("reset.stall", 16'(stall), 0);
        chk("reset.full", 16'(full), 0);
        chk("reset.cnt", 16'(cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //                name            rs0 rs1 used  em er mw mr ww wr is ir d dr fwd      st fl
        tbl[0] = mk("mem_over_wb",    5,  0, 2'b11, 0, 0, 1, 5, 1, 5, 0, 0, 0, 0, 4'b0010, 0, 0);
        tbl[1] = mk("wb_only",        5,  0, 2'b11, 0, 0, 0, 5, 1, 5, 0, 0, 0, 0, 4'b0011, 0, 0);
        tbl[2] = mk("rs0_zero",       0,  0, 2'b11, 0, 0, 0, 5, 1, 5, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[3] = mk("x0_gate",        0,  0, 2'b11, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[4] = mk("load_use",       0,  7, 2'b10, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        tbl[5] = mk("load_unused",    0,  7, 2'b01, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[6] = mk("two_src",        5,  6, 2'b11, 0, 0, 1, 6, 1, 5, 0, 0, 0, 0, 4'b1011, 0, 0);
        tbl[7] = mk("load_x0",        0,  0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[8] = mk("done_not_busy",  8,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 4'b0000, 0, 0);
        tbl[9] = mk("unused_fwd",     0,  9, 2'b01, 1, 9, 1, 9, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 0);
        for (int i = 0; i < 10; i++) step(tbl[i]);
        chk("table.cnt", 16'(cnt), 1);

        do_reset();
        step(sq("issue9_same_cycle", 9, 2'b01, 1, 9, 0, 0, 4'b0000, 0, 0));
        repeat (3) step(sq("busy9", 9, 2'b01, 0, 0, 0, 0, 4'b0000, 1, 0));
        step(sq("done9_bypass", 9, 2'b01, 0, 0, 1, 9, 4'b0001, 0, 0));
        step(sq("cleared9", 9, 2'b01, 0, 0, 0, 0, 4'b0000, 0, 0));
        chk("life.cnt", 16'(cnt), 3);

        do_reset();
        step(sq("issue3", 0, 0, 1, 3, 0, 0, 0, 0, 0));
        step(sq("issue4", 0, 0, 1, 4, 0, 0, 0, 0, 0));
        step(sq("issue5_full", 0, 0, 1, 5, 0, 0, 0, 1, 1));
        step(sq("rd5_not_set", 5, 2'b01, 0, 0, 0, 0, 0, 0, 1));
        step(sq("done4", 0, 0, 0, 0, 1, 4, 0, 0, 1));
        step(sq("waw3", 0, 0, 1, 3, 0, 0, 0, 1, 0));
        step(sq("issue3_done3", 0, 0, 1, 3, 1, 3, 0, 0, 0));
        step(sq("busy3_kept", 3, 2'b01, 0, 0, 0, 0, 0, 1, 0));
        step(sq("issue6", 0, 0, 1, 6, 0, 0, 0, 0, 0));
        step(sq("full_again", 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("waw.cnt", 16'(cnt), 3);

        do_reset();
        step(sq("done_empty", 0, 0, 0, 0, 1, 2, 0, 0, 0));
        step(sq("issue10", 0, 0, 1, 10, 0, 0, 0, 0, 0));
        step(sq("issue11", 0, 0, 1, 11, 0, 0, 0, 0, 0));
        step(sq("no_underflow", 0, 0, 0, 0, 0, 0, 0, 0, 1));

        do_reset();
        lu = mk("sat_load_use", 0, 7, 2'b10, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        repeat (14) step(lu);
        chk("sat.cnt14", 16'(cnt), 14);
        repeat (7) step(lu);
        chk("sat.cnt_max", 16'(cnt), 15);

        do_reset();
        step(sq("ar_issue3", 0, 0, 1, 3, 0, 0, 0, 0, 0));
        step(sq("ar_issue4", 0, 0, 1, 4, 0, 0, 0, 0, 0));
        hold3 = sq("ar_hold3", 3, 2'b01, 0, 0, 0, 0, 0, 1, 1);
        repeat (6) step(hold3);
        chk("ar.cnt_before", 16'(cnt), 6);
        chk("ar.full_before", 16'(full), 1);
        rst = 1'b1;
        #2;
        chk("ar.full", 16'(full), 0);
        chk("ar.cnt", 16'(cnt), 0);
        chk("ar.stall", 16'(stall), 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
